// File: rtl/nav_sample_sequencer.sv
// Data-ready driven read sequencer for the PMOD-NAV IMU: bursts 12 bytes over the
// byte-level SPI engine, packs gyro/accel words and queues timestamped samples.
module nav_sample_sequencer #(
    parameter logic [7:0] START_ADDR = 8'h18,
    parameter int         NBYTES     = 12,
    parameter int         FIFO_DEPTH = 4,
    parameter int         TS_W       = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_enable,
    input  logic            i_drdy,
    input  logic            i_ovr_clr,
    output logic            o_spi_req,
    output logic [7:0]      o_spi_tx,
    output logic            o_spi_cs_hold,
    input  logic            i_spi_ack,
    input  logic [7:0]      i_spi_rx,
    output logic            o_smp_valid,
    input  logic            i_smp_ready,
    output logic [95:0]     o_smp_data,
    output logic [TS_W-1:0] o_smp_ts,
    output logic            o_busy,
    output logic            o_overrun
);

    // state  | meaning
    // IDLE   | waiting for a data-ready edge (or a pending one) with enable set
    // CMD    | shifting the read command byte, chip select held
    // DATA   | shifting dummy bytes, capturing returned bytes
    // PUSH   | one cycle: write the sample to the FIFO or drop it
    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_PUSH} state_t;

    localparam int AW = $clog2(FIFO_DEPTH);

    state_t            r_state;
    state_t            w_next;
    logic              r_sync1, r_sync2, r_sync3;
    logic              w_drdy_rise;
    logic [TS_W-1:0]   r_ts_cnt;
    logic [TS_W-1:0]   r_ts_cap;
    logic [TS_W-1:0]   r_ts_pend;
    logic              r_pend;
    logic              r_ovr;
    logic [3:0]        r_byte_cnt;
    logic [95:0]       r_smp;
    logic [95:0]       r_fifo_data [FIFO_DEPTH];
    logic [TS_W-1:0]   r_fifo_ts   [FIFO_DEPTH];
    logic [AW:0]       r_wr_ptr, r_rd_ptr;
    logic              w_empty, w_full, w_pop, w_push, w_drop;
    logic              w_start, w_last_byte, w_ovr_set;

    assign w_drdy_rise = r_sync2 & ~r_sync3;
    assign w_last_byte = (r_byte_cnt == 4'(NBYTES - 1));
    assign w_start     = (r_state == S_IDLE) && i_enable && (w_drdy_rise || r_pend);

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = !w_empty && i_smp_ready;
    // A full FIFO still accepts the sample when the head leaves in the same cycle.
    assign w_push  = (r_state == S_PUSH) && (!w_full || w_pop);
    assign w_drop  = (r_state == S_PUSH) && w_full && !w_pop;
    assign w_ovr_set = w_drop || (w_drdy_rise && r_pend);

    assign o_busy      = (r_state != S_IDLE);
    assign o_overrun   = r_ovr;
    assign o_smp_valid = !w_empty;
    assign o_smp_data  = w_empty ? '0 : r_fifo_data[r_rd_ptr[AW-1:0]];
    assign o_smp_ts    = w_empty ? '0 : r_fifo_ts[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_CMD;
            S_CMD:   if (i_spi_ack) w_next = S_DATA;
            S_DATA:  if (i_spi_ack && w_last_byte) w_next = S_PUSH;
            S_PUSH:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_spi_req     = 1'b0;
        o_spi_cs_hold = 1'b0;
        o_spi_tx      = 8'h00;
        case (r_state)
            S_CMD: begin
                o_spi_req     = 1'b1;
                o_spi_cs_hold = 1'b1;
                o_spi_tx      = {1'b1, START_ADDR[6:0]};
            end
            S_DATA: begin
                o_spi_req     = 1'b1;
                o_spi_cs_hold = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_sync3    <= 1'b0;
            r_ts_cnt   <= '0;
            r_ts_cap   <= '0;
            r_ts_pend  <= '0;
            r_pend     <= 1'b0;
            r_ovr      <= 1'b0;
            r_byte_cnt <= '0;
            r_smp      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_sync1  <= i_drdy;
            r_sync2  <= r_sync1;
            r_sync3  <= r_sync2;
            r_ts_cnt <= r_ts_cnt + 1'b1;

            if (w_start) begin
                r_ts_cap <= r_pend ? r_ts_pend : r_ts_cnt;
                r_pend   <= 1'b0;
            end else if (w_drdy_rise && o_busy && !r_pend) begin
                r_pend    <= 1'b1;
                r_ts_pend <= r_ts_cnt;
            end

            if (r_state == S_CMD && i_spi_ack) begin
                r_byte_cnt <= '0;
            end else if (r_state == S_DATA && i_spi_ack) begin
                r_smp[{r_byte_cnt, 3'b000} +: 8] <= i_spi_rx;
                if (!w_last_byte) r_byte_cnt <= r_byte_cnt + 1'b1;
            end

            if (w_ovr_set)      r_ovr <= 1'b1;
            else if (i_ovr_clr) r_ovr <= 1'b0;

            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: contents are only visible while the FIFO is non-empty.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr[AW-1:0]] <= r_smp;
            r_fifo_ts[r_wr_ptr[AW-1:0]]   <= r_ts_cap;
        end
    end

endmodule
